// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Defining MULDIV_FAST_MULT_EN gives MULT/MULTU a single-cycle multiplier; DIV stays iterative.
module muldiv_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_func_code,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);
    localparam int unsigned CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {StIdle, StIter, StFixup} state_t;

    state_t                  r_state, w_state_d;
    logic [CW-1:0]           r_cnt, w_cnt_d;
    logic [2*DATA_W-1:0]     r_acc;
    logic [DATA_W-1:0]       r_opb;
    logic                    r_sign_a, r_sign_b, r_is_div, r_div0, r_busy;
    logic [DATA_W-1:0]       r_hi, r_lo;

    logic w_rtype, w_mfhi, w_mthi, w_mflo, w_mtlo, w_mult, w_multu, w_div, w_divu;
    logic w_mult_op, w_div_op, w_signed_op, w_md_op, w_accept, w_start;

    assign w_rtype     = (i_opcode == 6'h00);
    assign w_mfhi      = w_rtype & (i_func_code == 6'h10);
    assign w_mthi      = w_rtype & (i_func_code == 6'h11);
    assign w_mflo      = w_rtype & (i_func_code == 6'h12);
    assign w_mtlo      = w_rtype & (i_func_code == 6'h13);
    assign w_mult      = w_rtype & (i_func_code == 6'h18);
    assign w_multu     = w_rtype & (i_func_code == 6'h19);
    assign w_div       = w_rtype & (i_func_code == 6'h1A);
    assign w_divu      = w_rtype & (i_func_code == 6'h1B);
    assign w_mult_op   = w_mult | w_multu;
    assign w_div_op    = w_div | w_divu;
    assign w_signed_op = w_mult | w_div;
    assign w_md_op     = w_mfhi | w_mthi | w_mflo | w_mtlo | w_mult_op | w_div_op;

    assign w_accept = i_valid & ~i_flush & w_md_op & (r_state == StIdle);
    assign o_stall  = i_valid & w_md_op & (r_state != StIdle);

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0]        w_prod_u, w_fast_prod;

    assign w_prod_s    = $signed({{DATA_W{i_rs_data[DATA_W-1]}}, i_rs_data})
                       * $signed({{DATA_W{i_rt_data[DATA_W-1]}}, i_rt_data});
    assign w_prod_u    = {{DATA_W{1'b0}}, i_rs_data} * {{DATA_W{1'b0}}, i_rt_data};
    assign w_fast_prod = w_mult ? w_prod_s : w_prod_u;
    assign w_start     = w_accept & w_div_op;
`else
    assign w_start     = w_accept & (w_mult_op | w_div_op);
`endif

    logic              w_rs_neg, w_rt_neg;
    logic [DATA_W-1:0] w_rs_mag, w_rt_mag;

    assign w_rs_neg = w_signed_op & i_rs_data[DATA_W-1];
    assign w_rt_neg = w_signed_op & i_rt_data[DATA_W-1];
    assign w_rs_mag = w_rs_neg ? -i_rs_data : i_rs_data;
    assign w_rt_mag = w_rt_neg ? -i_rt_data : i_rt_data;

    // Multiply: multiplier sits in acc low half and is consumed LSB-first.
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(DATA_W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Divide: acc is {remainder, dividend/quotient}; quotient bits shift in from the right.
    logic [DATA_W:0]     w_rem_sh;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_div_sub;
    logic [2*DATA_W-1:0] w_div_next;

    assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
    assign w_div_sub  = w_rem_sh[DATA_W-1:0] - r_opb;
    assign w_div_next = {(w_div_ge ? w_div_sub : w_rem_sh[DATA_W-1:0]),
                         r_acc[DATA_W-2:0], w_div_ge};

    logic                w_neg_res;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_q_mag, w_q_neg, w_quot, w_r_mag, w_r_neg, w_rem;

    assign w_neg_res = r_sign_a ^ r_sign_b;
    assign w_prod    = w_neg_res ? -r_acc : r_acc;
    assign w_q_mag   = r_acc[DATA_W-1:0];
    assign w_q_neg   = -w_q_mag;
    assign w_r_mag   = r_acc[2*DATA_W-1:DATA_W];
    assign w_r_neg   = -w_r_mag;
    // Divide-by-zero forces LO to all ones; the restoring remainder already equals |rs|.
    assign w_quot    = r_div0 ? {DATA_W{1'b1}} : (w_neg_res ? w_q_neg : w_q_mag);
    assign w_rem     = r_sign_a ? w_r_neg : w_r_mag;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StIter;
                    w_cnt_d   = CW'(DATA_W - 1);
                end
            end
            StIter: begin
                if (i_flush) begin
                    w_state_d = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_d = StFixup;
                end else begin
                    w_cnt_d = r_cnt - CW'(1);
                end
            end
            StFixup: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= (w_state_d != StIdle);

            if (w_start) begin
                r_acc    <= {{DATA_W{1'b0}}, (w_div_op ? w_rs_mag : w_rt_mag)};
                r_opb    <= w_div_op ? w_rt_mag : w_rs_mag;
                r_sign_a <= w_rs_neg;
                r_sign_b <= w_rt_neg;
                r_is_div <= w_div_op;
                r_div0   <= (i_rt_data == '0);
            end else if (r_state == StIter) begin
                r_acc <= r_is_div ? w_div_next : w_mul_next;
            end

            if (w_accept && w_mthi) r_hi <= i_rs_data;
            if (w_accept && w_mtlo) r_lo <= i_rs_data;
`ifdef MULDIV_FAST_MULT_EN
            if (w_accept && w_mult_op) {r_hi, r_lo} <= w_fast_prod;
`endif
            if (r_state == StFixup && !i_flush) begin
                if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end else begin
                    {r_hi, r_lo} <= w_prod;
                end
            end
        end
    end

    always_comb begin
        o_result = '0;
        if (w_accept && w_mfhi) begin
            o_result = r_hi;
        end else if (w_accept && w_mflo) begin
            o_result = r_lo;
        end
    end

    assign o_result_valid = w_accept & (w_mfhi | w_mflo);
    assign o_busy         = r_busy;
    assign o_hi           = r_hi;
    assign o_lo           = r_lo;

endmodule
